bp_mem_cmd_delay_fifo: RTL

//  Latency-injecting in-order buffer between the proc mem_cmd two-fifo and the bp_mem model.

---
 rtl/bp_mem_cmd_delay_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/bp_mem_cmd_delay_fifo.sv
// bp_mem_cmd_delay_fifo: in-order command buffer that holds each entry for a per-entry
// delay (sampled from delay_i at enqueue) before the head may be released.
// Optional macro BP_MEM_DELAY_STATS_EN adds saturating dequeue/stall counters.
module bp_mem_cmd_delay_fifo #(
   parameter int unsigned width_p       = 128,
   parameter int unsigned els_p         = 4,
   parameter int unsigned delay_width_p = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [width_p-1:0]       data_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic [delay_width_p-1:0] delay_i,
   output logic [width_p-1:0]       data_o,
   output logic                     v_o,
   input  logic                     yumi_i,
   output logic [$clog2(els_p):0]   count_o
`ifdef BP_MEM_DELAY_STATS_EN
   ,
   output logic [31:0]              stat_cmds_o,
   output logic [31:0]              stat_stall_o
`endif
);

   localparam int unsigned PtrW = $clog2(els_p);
   localparam int unsigned CntW = PtrW + 1;

   logic [width_p-1:0]       mem_q [els_p];
   logic [delay_width_p-1:0] cnt_q [els_p];
   logic [delay_width_p-1:0] cnt_d [els_p];
   logic [els_p-1:0]         occ;
   logic [PtrW-1:0]          rd_q, rd_d, wr_q, wr_d;
   logic [CntW-1:0]          count_q, count_d;
   logic                     enq, deq;

   // ready_o looks only at registered count so it never depends on same-cycle yumi_i
   assign ready_o = reset_n_i & (count_q != CntW'(els_p));
   assign v_o     = (count_q != '0) & (cnt_q[rd_q] == '0);
   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   // Pointer/count next state and per-entry hold countdowns
   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q + CntW'(enq) - CntW'(deq);
      if (enq) wr_d = wr_q + PtrW'(1);
      if (deq) rd_d = rd_q + PtrW'(1);
      for (int i = 0; i < int'(els_p); i++) begin
         // Entry is occupied when its distance from the head is below the occupancy
         occ[i]   = CntW'(PtrW'(i) - rd_q) < count_q;
         cnt_d[i] = cnt_q[i];
         if (occ[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
         if (enq && (wr_q == PtrW'(i))) cnt_d[i] = delay_i;
      end
   end

   // Control state, cleared asynchronously
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(els_p); i++) cnt_q[i] <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         for (int i = 0; i < int'(els_p); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Payload storage; contents are meaningless until written, so no reset
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_q] <= data_i;
   end

`ifdef BP_MEM_DELAY_STATS_EN
   logic [31:0] stat_cmds_q, stat_cmds_d, stat_stall_q, stat_stall_d;

   // Saturating dequeue and stall counters
   always_comb begin
      stat_cmds_d  = stat_cmds_q;
      stat_stall_d = stat_stall_q;
      if (deq && (stat_cmds_q != 32'hFFFF_FFFF)) stat_cmds_d = stat_cmds_q + 32'd1;
      if ((count_q != '0) && !v_o && (stat_stall_q != 32'hFFFF_FFFF)) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stat_cmds_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_cmds_q  <= stat_cmds_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_cmds_o  = stat_cmds_q;
   assign stat_stall_o = stat_stall_q;
`endif

`ifndef SYNTHESIS
   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      yumi_i |-> v_o)
      else $error("yumi_i asserted while v_o is low");
`endif

endmodule
